// File: rtl/ballot_controller_if.sv
// ballot_controller_if
//   Bundles the debounced front-panel inputs and the display/LED outputs of
//   the ballot controller.
//   master : drives buttons and access code, observes tallies and status
//   slave  : the controller itself
//   Signals:
//     btn_1/2/3   candidate buttons (debounced level)
//     btn_ov_cv   open/close button (debounced level)
//     sw          16-bit access code
//     count_1/2/3 per-candidate tallies, vote_count total tally
//     the_state   0=CLOSED 1=OPEN/LOCKOUT 2=TALLY 3=RESULT
//     the_winner  0=none/tie, 1..3=candidate
//     enable_leds high while voting is open (OPEN or LOCKOUT)
//     vote_ack    one-cycle pulse per accepted vote
//     vote_reject one-cycle pulse per rejected press or bad code
interface ballot_controller_if #(
   parameter int CNT_W = 4
);
   logic             btn_1;
   logic             btn_2;
   logic             btn_3;
   logic             btn_ov_cv;
   logic [15:0]      sw;
   logic [CNT_W-1:0] count_1;
   logic [CNT_W-1:0] count_2;
   logic [CNT_W-1:0] count_3;
   logic [CNT_W-1:0] vote_count;
   logic [1:0]       the_state;
   logic [1:0]       the_winner;
   logic             enable_leds;
   logic             vote_ack;
   logic             vote_reject;

   modport master (
      output btn_1, btn_2, btn_3, btn_ov_cv, sw,
      input  count_1, count_2, count_3, vote_count,
      input  the_state, the_winner, enable_leds, vote_ack, vote_reject
   );

   modport slave (
      input  btn_1, btn_2, btn_3, btn_ov_cv, sw,
      output count_1, count_2, count_3, vote_count,
      output the_state, the_winner, enable_leds, vote_ack, vote_reject
   );
endinterface

// File: rtl/ballot_controller.sv
// ballot_controller
//   Sequencing and arbitration core of the voting machine. Opens/closes
//   voting by access code, accepts one vote per candidate-button press,
//   enforces a post-vote lockout, keeps saturating tallies and runs a
//   two-cycle tally to pick the winner.
//   Ports:
//     clk_100MHz  system clock
//     reset_n     asynchronous active-low reset
//     bus         ballot_controller_if.slave (buttons, code, tallies, status)
//   Optional build macro:
//     VOTE_TIMEOUT_EN  adds a 32-bit idle counter that closes voting after
//                      TIMEOUT_CYCLES clocks without an accepted vote.
module ballot_controller #(
   parameter int          CNT_W          = 4,
   parameter logic [15:0] OPEN_CODE      = 16'hA5A5,
   parameter logic [15:0] CLOSE_CODE     = 16'h5A5A,
   parameter int          LOCK_CYCLES    = 100_000_000,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd3_000_000_000
) (
   input  logic               clk_100MHz,
   input  logic               reset_n,
   ballot_controller_if.slave bus
);

   localparam int               LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_CLOSED,
      S_OPEN,
      S_LOCK,
      S_TALLY1,
      S_TALLY2,
      S_RESULT
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        hist_q;            // {ov_cv, btn_3, btn_2, btn_1} last sample
   logic [2:0]        cand_edge;
   logic              ov_edge, one_vote, multi_vote;
   logic              open_hit, close_hit, lock_done, timeout_hit;
   logic              accept, reject, do_clear;
   logic [CNT_W-1:0]  cnt_q [3];
   logic [CNT_W-1:0]  total_q;
   logic [CNT_W-1:0]  best_val_q;
   logic [1:0]        best_idx_q;
   logic              tie_q;
   logic [1:0]        winner_q;
   logic              ack_q, rej_q;
   logic [LOCK_W-1:0] lock_q;
   logic [1:0]        the_state_c;
   logic              leds_c;

   // Rising edges only; history resets high so a held button is not a press.
   assign cand_edge  = {bus.btn_3, bus.btn_2, bus.btn_1} & ~hist_q[2:0];
   assign ov_edge    = bus.btn_ov_cv & ~hist_q[3];
   assign one_vote   = (cand_edge == 3'b001) || (cand_edge == 3'b010) || (cand_edge == 3'b100);
   assign multi_vote = (cand_edge != 3'b000) && !one_vote;
   assign open_hit   = ov_edge && (bus.sw == OPEN_CODE);
   assign close_hit  = ov_edge && (bus.sw == CLOSE_CODE);
   assign lock_done  = (lock_q == LOCK_LAST);

`ifdef VOTE_TIMEOUT_EN
   logic [31:0] idle_q;

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n)
         idle_q <= '0;
      else if (do_clear || accept)
         idle_q <= '0;
      else if (state_q == S_OPEN || state_q == S_LOCK)
         idle_q <= idle_q + 32'd1;
      else
         idle_q <= '0;
   end

   // Fires on the cycle the count would reach TIMEOUT_CYCLES.
   assign timeout_hit = (state_q == S_OPEN || state_q == S_LOCK) &&
                        (idle_q == TIMEOUT_CYCLES - 32'd1);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;   // only meaningful with the timeout build
   assign timeout_hit    = 1'b0;
`endif

   // State register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) state_q <= S_CLOSED;
      else          state_q <= state_d;
   end

   // Next-state and per-cycle strobes
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_d  = state_q;
      accept   = 1'b0;
      reject   = 1'b0;
      do_clear = 1'b0;
      case (state_q)
         S_CLOSED, S_RESULT: begin
            if (open_hit) begin
               state_d  = S_OPEN;
               do_clear = 1'b1;
            end else if (ov_edge) begin
               reject = 1'b1;
            end
         end
         S_OPEN: begin
            accept = one_vote;
            // An accepted vote owns the status pulse; a bad code in the same
            // cycle is not additionally flagged.
            reject = multi_vote || (ov_edge && !close_hit && !one_vote);
            if (close_hit || timeout_hit)  state_d = S_TALLY1;
            else if (one_vote || multi_vote) state_d = S_LOCK;
         end
         S_LOCK: begin
            reject = (cand_edge != 3'b000) || (ov_edge && !close_hit);
            if (close_hit || timeout_hit) state_d = S_TALLY1;
            else if (lock_done)           state_d = S_OPEN;
         end
         S_TALLY1: state_d = S_TALLY2;
         S_TALLY2: state_d = S_RESULT;
         default:  state_d = S_CLOSED;
      endcase
   end

   // Status decode of the state register
   always_comb begin
      the_state_c = 2'd0;
      leds_c      = 1'b0;
      case (state_q)
         S_OPEN, S_LOCK: begin
            the_state_c = 2'd1;
            leds_c      = 1'b1;
         end
         S_TALLY1, S_TALLY2: the_state_c = 2'd2;
         S_RESULT:           the_state_c = 2'd3;
         default:            the_state_c = 2'd0;
      endcase
   end

   // Datapath: edge history, tallies, lockout timer, tally pipeline
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         hist_q     <= '1;
         // NOTE: the tally array is only three counters, so it is reset like any other register.
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
         total_q    <= '0;
         best_val_q <= '0;
         best_idx_q <= 2'd0;
         tie_q      <= 1'b0;
         winner_q   <= 2'd0;
         ack_q      <= 1'b0;
         rej_q      <= 1'b0;
         lock_q     <= '0;
      end else begin
         hist_q <= {bus.btn_ov_cv, bus.btn_3, bus.btn_2, bus.btn_1};
         ack_q  <= accept;
         rej_q  <= reject;
         lock_q <= (state_q == S_LOCK) ? lock_q + LOCK_W'(1) : '0;

         if (do_clear) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            total_q  <= '0;
            winner_q <= 2'd0;
         end else if (accept) begin
            for (int i = 0; i < 3; i++)
               if (cand_edge[i] && cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            if (total_q != CNT_MAX) total_q <= total_q + CNT_W'(1);
         end

         if (state_q == S_TALLY1) begin
            if (cnt_q[0] > cnt_q[1]) begin
               best_val_q <= cnt_q[0];
               best_idx_q <= 2'd1;
               tie_q      <= 1'b0;
            end else if (cnt_q[1] > cnt_q[0]) begin
               best_val_q <= cnt_q[1];
               best_idx_q <= 2'd2;
               tie_q      <= 1'b0;
            end else begin
               best_val_q <= cnt_q[0];
               best_idx_q <= 2'd1;
               tie_q      <= 1'b1;
            end
         end

         // Equality on the max is a tie; all-zero counts land here as a tie too.
         if (state_q == S_TALLY2) begin
            if (cnt_q[2] > best_val_q)       winner_q <= 2'd3;
            else if (cnt_q[2] == best_val_q) winner_q <= 2'd0;
            else                             winner_q <= tie_q ? 2'd0 : best_idx_q;
         end
      end
   end

   assign bus.count_1     = cnt_q[0];
   assign bus.count_2     = cnt_q[1];
   assign bus.count_3     = cnt_q[2];
   assign bus.vote_count  = total_q;
   assign bus.the_winner  = winner_q;
   assign bus.vote_ack    = ack_q;
   assign bus.vote_reject = rej_q;
   assign bus.the_state   = the_state_c;
   assign bus.enable_leds = leds_c;

endmodule

// File: tb/tb_ballot_controller.sv
// tb_ballot_controller
//   Self-checking bench for ballot_controller. A tally model kept as plain
//   integers predicts counts, acks/rejects and the winner.
module tb_ballot_controller;

   localparam int          CNT_W   = 4;
   localparam int          LOCK    = 4;
   localparam int unsigned CMAX    = (1 << CNT_W) - 1;
   localparam logic [15:0] OPEN_C  = 16'hA5A5;
   localparam logic [15:0] CLOSE_C = 16'h5A5A;
`ifdef VOTE_TIMEOUT_EN
   localparam logic [31:0] TMO = 32'd20;
`else
   localparam logic [31:0] TMO = 32'd3_000_000_000;
`endif

   logic clk_100MHz = 1'b0;
   logic reset_n    = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   ballot_controller_if #(.CNT_W(CNT_W)) bus ();

   ballot_controller #(
      .CNT_W(CNT_W), .OPEN_CODE(OPEN_C), .CLOSE_CODE(CLOSE_C),
      .LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .reset_n   (reset_n),
      .bus       (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Tally model
   int unsigned m_cnt [3];
   int unsigned m_total;

   task automatic model_clear();
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_total = 0;
   endtask

   task automatic model_vote(input logic [2:0] m, output bit accepted);
      accepted = ($countones(m) == 1);
      if (accepted) begin
         for (int i = 0; i < 3; i++) if (m[i] && m_cnt[i] < CMAX) m_cnt[i]++;
         if (m_total < CMAX) m_total++;
      end
   endtask

   // Unique maximum wins; a shared maximum or an empty ballot gives 0.
   function automatic logic [1:0] model_winner();
      int unsigned best = 0;
      int          idx  = 0;
      int          n    = 0;
      for (int i = 0; i < 3; i++) if (m_cnt[i] > best) begin best = m_cnt[i]; idx = i + 1; end
      for (int i = 0; i < 3; i++) if (m_cnt[i] == best) n++;
      return (best == 0 || n > 1) ? 2'd0 : 2'(idx);
   endfunction

   function automatic logic [4*CNT_W-1:0] model_counts();
      return {CNT_W'(m_cnt[0]), CNT_W'(m_cnt[1]), CNT_W'(m_cnt[2]), CNT_W'(m_total)};
   endfunction

   // Stimulus helpers: outputs read after tick() reflect the edge just taken.
   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic drive_btn(input logic [2:0] m);
      // NOTE: bench inputs use blocking assignments, applied 1 time unit after the clock edge.
      {bus.btn_3, bus.btn_2, bus.btn_1} = m;
      tick();
      {bus.btn_3, bus.btn_2, bus.btn_1} = 3'b000;
   endtask

   task automatic drive_ov(input logic [15:0] code);
      bus.sw        = code;
      bus.btn_ov_cv = 1'b1;
      tick();
      bus.btn_ov_cv = 1'b0;
   endtask

   function automatic logic [4*CNT_W-1:0] dut_counts();
      return {bus.count_1, bus.count_2, bus.count_3, bus.vote_count};
   endfunction

   // ------------------------------------------------------------------
   task automatic test_reset();
      bus.btn_1 = 1'b1; bus.btn_2 = 1'b0; bus.btn_3 = 1'b0;
      bus.btn_ov_cv = 1'b0; bus.sw = 16'h0000;
      reset_n = 1'b0;
      idle(3);
      n_total++;
      if ({bus.the_state, bus.the_winner, bus.enable_leds, bus.vote_ack, bus.vote_reject} !== 7'b0)
         $display("FAIL reset_status: got %b expected 0000000",
                  {bus.the_state, bus.the_winner, bus.enable_leds, bus.vote_ack, bus.vote_reject});
      else n_pass++;
      n_total++;
      if (dut_counts() !== '0) $display("FAIL reset_counts: got %h expected 0", dut_counts());
      else n_pass++;

      reset_n = 1'b1;
      idle(2);
      drive_ov(OPEN_C);
      model_clear();
      n_total++;
      if (bus.the_state !== 2'd1 || bus.enable_leds !== 1'b1)
         $display("FAIL open_after_reset: state %0d leds %b expected 1 1", bus.the_state, bus.enable_leds);
      else n_pass++;
      idle(2);
      n_total++;
      if (dut_counts() !== model_counts() || bus.vote_ack !== 1'b0)
         $display("FAIL held_btn_no_vote: counts %h ack %b expected %h 0", dut_counts(), bus.vote_ack, model_counts());
      else n_pass++;
      bus.btn_1 = 1'b0;
      tick();
   endtask

   task automatic test_tally_basic();
      logic [2:0] seq [6] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100};
      bit acc;
      foreach (seq[i]) begin
         drive_btn(seq[i]);
         model_vote(seq[i], acc);
         n_total++;
         if (bus.vote_ack !== acc || bus.vote_reject !== 1'b0 || dut_counts() !== model_counts())
            $display("FAIL basic_vote%0d: ack %b rej %b counts %h expected %b 0 %h",
                     i, bus.vote_ack, bus.vote_reject, dut_counts(), acc, model_counts());
         else n_pass++;
         tick();
         n_total++;
         if (bus.vote_ack !== 1'b0) $display("FAIL basic_ack_pulse%0d: ack %b expected 0", i, bus.vote_ack);
         else n_pass++;
         idle(LOCK - 1);
      end
      drive_ov(CLOSE_C);
      n_total++;
      if (bus.the_state !== 2'd2) $display("FAIL tally_c1: state %0d expected 2", bus.the_state);
      else n_pass++;
      tick();
      n_total++;
      if (bus.the_state !== 2'd2) $display("FAIL tally_c2: state %0d expected 2", bus.the_state);
      else n_pass++;
      tick();
      n_total++;
      if (bus.the_state !== 2'd3 || bus.the_winner !== model_winner() || bus.enable_leds !== 1'b0)
         $display("FAIL basic_result: state %0d winner %0d leds %b expected 3 %0d 0",
                  bus.the_state, bus.the_winner, bus.enable_leds, model_winner());
      else n_pass++;
      n_total++;
      if (dut_counts() !== model_counts()) $display("FAIL basic_counts: got %h expected %h", dut_counts(), model_counts());
      else n_pass++;
   endtask

   task automatic test_reject();
      bit acc;
      drive_ov(OPEN_C);
      model_clear();
      n_total++;
      if (bus.the_state !== 2'd1 || bus.the_winner !== 2'd0 || dut_counts() !== model_counts())
         $display("FAIL reopen_clear: state %0d winner %0d counts %h expected 1 0 %h",
                  bus.the_state, bus.the_winner, dut_counts(), model_counts());
      else n_pass++;

      drive_btn(3'b101);
      model_vote(3'b101, acc);
      n_total++;
      if (bus.vote_reject !== 1'b1 || bus.vote_ack !== 1'b0 || dut_counts() !== model_counts())
         $display("FAIL multi_press: rej %b ack %b counts %h expected 1 0 %h",
                  bus.vote_reject, bus.vote_ack, dut_counts(), model_counts());
      else n_pass++;
      tick();
      n_total++;
      if (bus.vote_reject !== 1'b0) $display("FAIL multi_pulse_width: rej %b expected 0", bus.vote_reject);
      else n_pass++;
      idle(LOCK - 1);

      drive_btn(3'b001);
      model_vote(3'b001, acc);
      n_total++;
      if (bus.vote_ack !== 1'b1) $display("FAIL vote_before_lock: ack %b expected 1", bus.vote_ack);
      else n_pass++;
      tick();
      drive_btn(3'b010);
      n_total++;
      if (bus.vote_reject !== 1'b1 || bus.vote_ack !== 1'b0 || dut_counts() !== model_counts())
         $display("FAIL lockout_press: rej %b ack %b counts %h expected 1 0 %h",
                  bus.vote_reject, bus.vote_ack, dut_counts(), model_counts());
      else n_pass++;
      idle(LOCK - 2);
   endtask

   task automatic test_tie_saturation();
      logic [2:0] seq [4] = '{3'b001, 3'b010, 3'b010, 3'b100};
      bit acc;
      foreach (seq[i]) begin
         drive_btn(seq[i]);
         model_vote(seq[i], acc);
         idle(LOCK);
      end
      n_total++;
      if (dut_counts() !== model_counts()) $display("FAIL tie_counts: got %h expected %h", dut_counts(), model_counts());
      else n_pass++;
      drive_ov(CLOSE_C);
      idle(2);
      n_total++;
      if (bus.the_state !== 2'd3 || bus.the_winner !== model_winner())
         $display("FAIL tie_winner: state %0d winner %0d expected 3 %0d", bus.the_state, bus.the_winner, model_winner());
      else n_pass++;

      drive_ov(OPEN_C);
      model_clear();
      for (int i = 0; i < 16; i++) begin
         drive_btn(3'b010);
         model_vote(3'b010, acc);
         n_total++;
         if (bus.vote_ack !== 1'b1 || dut_counts() !== model_counts())
            $display("FAIL sat_vote%0d: ack %b counts %h expected 1 %h", i, bus.vote_ack, dut_counts(), model_counts());
         else n_pass++;
         idle(LOCK);
      end
   endtask

   task automatic test_bad_code();
      drive_ov(16'h0000);
      n_total++;
      if (bus.vote_reject !== 1'b1 || bus.the_state !== 2'd1)
         $display("FAIL badcode_open: rej %b state %0d expected 1 1", bus.vote_reject, bus.the_state);
      else n_pass++;
      tick();
      drive_ov(CLOSE_C);
      idle(2);
      drive_ov(16'h0000);
      n_total++;
      if (bus.vote_reject !== 1'b1 || bus.the_state !== 2'd3 || bus.the_winner !== model_winner())
         $display("FAIL badcode_result: rej %b state %0d winner %0d expected 1 3 %0d",
                  bus.vote_reject, bus.the_state, bus.the_winner, model_winner());
      else n_pass++;
      tick();

      drive_ov(OPEN_C);
      model_clear();
      drive_btn(3'b001);
      #2 reset_n = 1'b0;
      #1;
      model_clear();
      n_total++;
      if ({bus.the_state, bus.the_winner, bus.enable_leds, bus.vote_ack, bus.vote_reject} !== 7'b0 ||
          dut_counts() !== model_counts())
         $display("FAIL async_reset_lockout: status %b counts %h expected 0000000 %h",
                  {bus.the_state, bus.the_winner, bus.enable_leds, bus.vote_ack, bus.vote_reject},
                  dut_counts(), model_counts());
      else n_pass++;
      @(posedge clk_100MHz);
      #1 reset_n = 1'b1;
      idle(2);

      drive_ov(16'h0000);
      n_total++;
      if (bus.vote_reject !== 1'b1 || bus.the_state !== 2'd0)
         $display("FAIL badcode_closed: rej %b state %0d expected 1 0", bus.vote_reject, bus.the_state);
      else n_pass++;
      tick();
      drive_btn(3'b010);
      n_total++;
      if (bus.vote_ack !== 1'b0 || bus.vote_reject !== 1'b0 || dut_counts() !== model_counts())
         $display("FAIL closed_press: ack %b rej %b counts %h expected 0 0 %h",
                  bus.vote_ack, bus.vote_reject, dut_counts(), model_counts());
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      bit          acc;
      logic [2:0]  m;
      logic [15:0] code;
      int          r;
      drive_ov(OPEN_C);
      model_clear();
      tick();
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7) begin
            m = 3'($urandom_range(1, 7));
            drive_btn(m);
            model_vote(m, acc);
            n_total++;
            if (bus.vote_ack !== acc || bus.vote_reject !== !acc || dut_counts() !== model_counts())
               $display("FAIL rand_vote%0d m=%b: ack %b rej %b counts %h expected %b %b %h",
                        i, m, bus.vote_ack, bus.vote_reject, dut_counts(), acc, !acc, model_counts());
            else n_pass++;
            idle(LOCK);
         end else if (r == 7) begin
            code = 16'($urandom);
            if (code == CLOSE_C) code = code ^ 16'h0001;
            drive_ov(code);
            n_total++;
            if (bus.vote_reject !== 1'b1 || bus.vote_ack !== 1'b0 || bus.the_state !== 2'd1)
               $display("FAIL rand_badcode%0d: rej %b ack %b state %0d expected 1 0 1",
                        i, bus.vote_reject, bus.vote_ack, bus.the_state);
            else n_pass++;
            tick();
         end else begin
            drive_ov(CLOSE_C);
            idle(2);
            n_total++;
            if (bus.the_state !== 2'd3 || bus.the_winner !== model_winner() || dut_counts() !== model_counts())
               $display("FAIL rand_close%0d: state %0d winner %0d counts %h expected 3 %0d %h",
                        i, bus.the_state, bus.the_winner, dut_counts(), model_winner(), model_counts());
            else n_pass++;
            drive_ov(OPEN_C);
            model_clear();
            tick();
         end
      end
   endtask

   task automatic test_back_to_back();
      bit acc;
      bus.btn_3     = 1'b1;
      bus.sw        = CLOSE_C;
      bus.btn_ov_cv = 1'b1;
      tick();
      bus.btn_3     = 1'b0;
      bus.btn_ov_cv = 1'b0;
      model_vote(3'b100, acc);
      n_total++;
      if (bus.vote_ack !== 1'b1 || bus.vote_reject !== 1'b0 || bus.the_state !== 2'd2 ||
          dut_counts() !== model_counts())
         $display("FAIL vote_with_close: ack %b rej %b state %0d counts %h expected 1 0 2 %h",
                  bus.vote_ack, bus.vote_reject, bus.the_state, dut_counts(), model_counts());
      else n_pass++;
      idle(2);
      n_total++;
      if (bus.the_state !== 2'd3 || bus.the_winner !== model_winner())
         $display("FAIL vote_with_close_result: state %0d winner %0d expected 3 %0d",
                  bus.the_state, bus.the_winner, model_winner());
      else n_pass++;
   endtask

`ifdef VOTE_TIMEOUT_EN
   task automatic test_timeout();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      idle(2);
      drive_ov(OPEN_C);
      model_clear();
      idle(int'(TMO) - 1);
      n_total++;
      if (bus.the_state !== 2'd1) $display("FAIL timeout_early: state %0d expected 1", bus.the_state);
      else n_pass++;
      tick();
      n_total++;
      if (bus.the_state !== 2'd2) $display("FAIL timeout_tally: state %0d expected 2", bus.the_state);
      else n_pass++;
      idle(2);
      n_total++;
      if (bus.the_state !== 2'd3 || bus.the_winner !== model_winner())
         $display("FAIL timeout_result: state %0d winner %0d expected 3 %0d",
                  bus.the_state, bus.the_winner, model_winner());
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
`ifdef VOTE_TIMEOUT_EN
      test_timeout();
`else
      test_tally_basic();
      test_reject();
      test_tie_saturation();
      test_bad_code();
      test_random();
      test_back_to_back();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
